// File: rtl/uart_pkg.sv
// Shared UART framing definitions for uart_rx and uart_tx.
// State encoding, default framing constants and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    localparam int DATA_BITS_DEF  = 8;
    localparam int OVERSAMPLE_DEF = 16;

    // XOR of all bits: 1 when the count of ones is odd
    function automatic logic parity_of(input logic [8:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous input.
// ResetVal sets the value both flops take while in reset.
module bit_synchronizer #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // two-stage capture of the async input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= ResetVal;
            q    <= ResetVal;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with a valid/ready byte output.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DataBits   = DATA_BITS_DEF,
    parameter int Oversample = OVERSAMPLE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_tick,
    input  logic                rxd,
    output logic [DataBits-1:0] data,
    output logic                valid,
    input  logic                ready,
    output logic                framing_error,
    output logic                overrun,
    output logic                busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                parity_error
`endif
);

    localparam int CW = $clog2(Oversample);
    localparam int IW = $clog2(DataBits);
    localparam logic [CW-1:0] HALF = CW'(Oversample / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(Oversample - 1);
    localparam logic [IW-1:0] LAST = IW'(DataBits - 1);

    uart_state_e         state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [IW-1:0]       idx, idx_n;
    logic [DataBits-1:0] shift, shift_n;
    logic                line;
    logic                done_ok;
    logic                done_bad;
    logic                good;
`ifdef UART_RX_PARITY_EN
    logic                pbit, pbit_n;
    logic                par_bad;
`endif

    bit_synchronizer #(.ResetVal(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (line)
    );

    assign busy = (state != IDLE);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // frame sequencing, evaluated only on oversample ticks
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shift_n  = shift;
        done_ok  = 1'b0;
        done_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbit_n   = pbit;
`endif
        if (sample_tick) begin
            unique case (state)
                IDLE: begin
                    if (!line) begin
                        state_n = START;
                        cnt_n   = '0;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt_n   = '0;
                        idx_n   = '0;
                        state_n = line ? IDLE : DATA;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL) begin
                        cnt_n        = '0;
                        shift_n[idx] = line;
                        if (idx == LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (cnt == FULL) begin
                        cnt_n   = '0;
                        pbit_n  = line;
                        state_n = STOP;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
`else
                    state_n = IDLE;
`endif
                end
                STOP: begin
                    if (cnt == FULL) begin
                        cnt_n = '0;
                        if (line) begin
                            state_n = IDLE;
                            done_ok = 1'b1;
                        end else begin
                            state_n  = BREAK;
                            done_bad = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (line) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign par_bad = parity_of(9'(shift)) ^ pbit;
    assign good    = done_ok && !par_bad;
`else
    assign good    = done_ok;
`endif

    // counters, shift register, output buffer and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            idx           <= '0;
            shift         <= '0;
            data          <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit          <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            cnt           <= cnt_n;
            idx           <= idx_n;
            shift         <= shift_n;
            framing_error <= done_bad;
            overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit          <= pbit_n;
            parity_error  <= done_ok && par_bad;
`endif
            if (good) begin
                if (!valid || ready) begin
                    data  <= shift;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx (8 data bits, Oversample 16).
// Frames are serialized from whole bytes; expected bytes and flag counts come from a frame-level model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rxd = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    uart_rx #(.DataBits(8), .Oversample(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_tick   (sample_tick),
        .rxd           (rxd),
        .data          (data),
        .valid         (valid),
        .ready         (ready),
        .framing_error (framing_error),
        .overrun       (overrun),
        .busy          (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error  (parity_error)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int exp_ferr = 0, obs_ferr = 0;
    int exp_ovr = 0, obs_ovr = 0;
    int exp_perr = 0, obs_perr = 0;
    logic [7:0] exp_q[$];
    bit mdl_full = 0;
    int tick_div = 1;
    int tcnt = 0;
    logic [7:0] prev_data = '0;
    bit prev_hold = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one tick every tick_div clocks
    always @(negedge clk) begin
        if (tcnt + 1 >= tick_div) tcnt = 0;
        else tcnt = tcnt + 1;
        sample_tick = (tcnt == 0);
    end

    // monitor: scoreboard pops on each accepted byte, counts flag pulses
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (framing_error) obs_ferr++;
            if (overrun) obs_ovr++;
`ifdef UART_RX_PARITY_EN
            if (parity_error) obs_perr++;
`endif
            if (prev_hold) chk("data_hold", data, prev_data);
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none", data);
                end else begin
                    chk("rx_byte", data, exp_q.pop_front());
                end
            end
            prev_hold = valid && !ready;
            prev_data = data;
        end else begin
            prev_hold = 0;
        end
    end

    // frame-level reference: what a whole frame should produce
    task automatic expect_frame(input logic [7:0] b, input bit stop_ok,
                                input bit par_ok);
        if (!stop_ok) exp_ferr++;
`ifdef UART_RX_PARITY_EN
        else if (!par_ok) exp_perr++;
`endif
        else if (mdl_full) exp_ovr++;
        else begin
            exp_q.push_back(b);
            if (!ready) mdl_full = 1;
        end
    endtask

    task automatic line_bits(input logic b, input int nbits);
        rxd = b;
        repeat (nbits * 16 * tick_div) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok = 1,
                        input bit par_ok = 1);
        expect_frame(b, stop_ok, par_ok);
        line_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) line_bits(b[i], 1);
`ifdef UART_RX_PARITY_EN
        line_bits((^b) ^ ~par_ok, 1);
`endif
        line_bits(stop_ok, 1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bit sok;
        @(negedge clk);
        repeat (2) @(negedge clk);
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", framing_error, 0);
        chk("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hA5);
        line_bits(1'b1, 2);
        drain("a5_drain");
        chk("a5_ferr", obs_ferr, exp_ferr);

        rxd = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy_hi", busy, 1);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_ferr", obs_ferr, exp_ferr);

        send(8'h3C, 0);
        line_bits(1'b0, 40);
        chk("break_busy", busy, 1);
        chk("break_ferr", obs_ferr, exp_ferr);
        line_bits(1'b1, 2);
        chk("break_exit", busy, 0);
        send(8'h96);
        line_bits(1'b1, 1);
        drain("break_drain");

        ready = 1'b0;
        send(8'h11);
        send(8'h22);
        line_bits(1'b1, 1);
        chk("ovr_valid", valid, 1);
        chk("ovr_data", data, 8'h11);
        chk("ovr_count", obs_ovr, exp_ovr);
        ready = 1'b1;
        mdl_full = 0;
        drain("ovr_drain");
        @(negedge clk);
        chk("ovr_valid_fall", valid, 0);

        send(8'h01);
        send(8'h02);
        line_bits(1'b1, 1);
        drain("b2b_drain");
        chk("b2b_ovr", obs_ovr, exp_ovr);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1, 1);
        send(8'h07, 1, 0);
        line_bits(1'b1, 1);
        drain("par_drain");
        chk("par_perr", obs_perr, exp_perr);
`endif

        b = 8'h5A;
        line_bits(1'b0, 1);
        for (int i = 0; i < 3; i++) line_bits(b[i], 1);
        rxd = b[3];
        repeat (8) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_ferr", framing_error, 0);
        chk("mid_rst_ovr", overrun, 0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send(8'h5A);
        line_bits(1'b1, 1);
        drain("post_rst_drain");

        for (int k = 0; k < 24; k++) begin
            if (k % 8 == 0) tick_div = $urandom_range(1, 3);
            b = 8'($urandom);
            sok = ($urandom_range(0, 5) != 0);
            send(b, sok);
            if (!sok) line_bits(1'b1, 2);
            else line_bits(1'b1, $urandom_range(0, 1));
        end
        line_bits(1'b1, 2);
        drain("rand_drain");
        chk("final_ferr", obs_ferr, exp_ferr);
        chk("final_ovr", obs_ovr, exp_ovr);
        chk("final_perr", obs_perr, exp_perr);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
